// File: rtl/rv32_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// rv32_ctrl_pkg
//
// Shared type definitions for the RV32 run controller, the core top that
// instantiates it, and the benches that drive it.
//
//   run_state_t  : controller FSM state (HALTED, RUN, RUNN, STEP)
//   cmd_op_t     : encoding of the cmd_op port
//   halt_cause_t : encoding of the halt_cause port
// ----------------------------------------------------------------------------
package rv32_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_HALTED = 2'd0,
      ST_RUN    = 2'd1,
      ST_RUNN   = 2'd2,
      ST_STEP   = 2'd3
   } run_state_t;

   typedef enum logic [1:0] {
      OP_RUN  = 2'd0,
      OP_HALT = 2'd1,
      OP_STEP = 2'd2,
      OP_RUNN = 2'd3
   } cmd_op_t;

   typedef enum logic [2:0] {
      CAUSE_NONE  = 3'd0,
      CAUSE_CMD   = 3'd1,
      CAUSE_BP    = 3'd2,
      CAUSE_STOP  = 3'd3,
      CAUSE_COUNT = 3'd4
   } halt_cause_t;

endpackage

// File: rtl/rv32_run_ctrl.sv
// ----------------------------------------------------------------------------
// rv32_run_ctrl
//
// Run/halt controller for an RV32 core. Decides, cycle by cycle, whether the
// core commits an instruction (core_en), driven by debugger-style commands,
// a single PC breakpoint, an external stop request and an instruction budget.
//
// Ports:
//   clk         in   core clock, all state changes on the rising edge
//   rst         in   synchronous reset, active low
//   cmd_valid   in   command request
//   cmd_ready   out  command accepted when cmd_valid && cmd_ready
//   cmd_op      in   [1:0]  RUN / HALT / STEP / RUNN
//   cmd_arg     in   [31:0] instruction budget for RUNN
//   bp_en       in   breakpoint enable
//   bp_addr     in   [31:0] breakpoint PC
//   cur_pc      in   [31:0] PC the core would execute at the next edge
//   Stop_en     in   external stop request, level sensitive
//   core_en     out  core commits one instruction at this edge
//   halted      out  controller is in HALTED
//   halt_cause  out  [2:0] reason for the most recent halt
//   cmd_err     out  one-cycle pulse after an accepted-but-ignored command
//   cycle_cnt   out  [31:0] number of core_en cycles, wraps
// ----------------------------------------------------------------------------
module rv32_run_ctrl
   import rv32_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [31:0] cmd_arg,
   input  logic        bp_en,
   input  logic [31:0] bp_addr,
   input  logic [31:0] cur_pc,
   input  logic        Stop_en,
   output logic        core_en,
   output logic        halted,
   output logic [2:0]  halt_cause,
   output logic        cmd_err,
   output logic [31:0] cycle_cnt
);

   run_state_t  state_q,     state_d;
   halt_cause_t cause_q,     cause_d;
   logic [31:0] remaining_q, remaining_d;
   logic        bp_skip_q,   bp_skip_d;
   logic        cmd_err_q,   cmd_err_d;
   logic [31:0] cycle_cnt_q;

   cmd_op_t     op;
   logic        cmd_accept;
   logic        halt_cmd;
   logic        bp_match;

   assign op = cmd_op_t'(cmd_op);

   // Ready depends only on state, Stop_en and reset, never on cmd_valid, so
   // the accept term below carries no combinational loop.
   assign cmd_ready = rst && ((state_q == ST_RUN) || (state_q == ST_RUNN) ||
                              ((state_q == ST_HALTED) && !Stop_en));

   assign cmd_accept = cmd_valid && cmd_ready;
   assign halt_cmd   = cmd_accept && (op == OP_HALT);

   // The skip flag masks the match on the first running cycle so the core can
   // resume from the very PC it stopped on.
   assign bp_match = bp_en && (cur_pc == bp_addr) && !bp_skip_q;

   assign halted     = (state_q == ST_HALTED);
   assign halt_cause = cause_q;
   assign cmd_err    = cmd_err_q;
   assign cycle_cnt  = cycle_cnt_q;

   // Next-state and core_en decode. Inside RUN/RUNN the halt sources are
   // ranked stop > HALT command > breakpoint; only if none fires does the core
   // commit, and only a committing RUNN cycle can exhaust the budget.
   always_comb begin
      state_d     = state_q;
      cause_d     = cause_q;
      remaining_d = remaining_q;
      bp_skip_d   = bp_skip_q;
      cmd_err_d   = 1'b0;
      core_en     = 1'b0;

      case (state_q)
         ST_HALTED: begin
            if (cmd_accept) begin
               case (op)
                  OP_RUN: begin
                     state_d   = ST_RUN;
                     bp_skip_d = 1'b1;
                  end
                  OP_STEP: begin
                     state_d = ST_STEP;
                  end
                  OP_RUNN: begin
                     if (cmd_arg != 32'd0) begin
                        state_d     = ST_RUNN;
                        remaining_d = cmd_arg;
                        bp_skip_d   = 1'b1;
                     end else begin
                        cause_d = CAUSE_COUNT;
                     end
                  end
                  OP_HALT: begin
                     cause_d = CAUSE_CMD;
                  end
                  default: ;
               endcase
            end
         end

         ST_RUN, ST_RUNN: begin
            bp_skip_d = 1'b0;
            cmd_err_d = cmd_accept && (op != OP_HALT);
            if (Stop_en) begin
               state_d = ST_HALTED;
               cause_d = CAUSE_STOP;
            end else if (halt_cmd) begin
               state_d = ST_HALTED;
               cause_d = CAUSE_CMD;
            end else if (bp_match) begin
               state_d = ST_HALTED;
               cause_d = CAUSE_BP;
            end else begin
               core_en = 1'b1;
               if (state_q == ST_RUNN) begin
                  remaining_d = remaining_q - 32'd1;
                  if (remaining_q == 32'd1) begin
                     state_d = ST_HALTED;
                     cause_d = CAUSE_COUNT;
                  end
               end
            end
         end

         ST_STEP: begin
            state_d = ST_HALTED;
            if (Stop_en) begin
               cause_d = CAUSE_STOP;
            end else begin
               core_en = 1'b1;
               cause_d = CAUSE_COUNT;
            end
         end

         default: state_d = ST_HALTED;
      endcase

      // Nothing may commit while reset is held, whatever the state says.
      if (!rst) begin
         core_en = 1'b0;
      end
   end

   // State, budget, skip flag, error pulse and the commit counter. Reset
   // drops any outstanding budget so a later run starts clean.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= ST_HALTED;
         cause_q     <= CAUSE_NONE;
         remaining_q <= 32'd0;
         bp_skip_q   <= 1'b0;
         cmd_err_q   <= 1'b0;
         cycle_cnt_q <= 32'd0;
      end else begin
         state_q     <= state_d;
         cause_q     <= cause_d;
         remaining_q <= remaining_d;
         bp_skip_q   <= bp_skip_d;
         cmd_err_q   <= cmd_err_d;
         if (core_en) begin
            cycle_cnt_q <= cycle_cnt_q + 32'd1;
         end
      end
   end

endmodule

// File: doc/rv32_run_ctrl.md
RV32_RUN_CTRL -- requirements
Module: rv32_run_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset. Ports are clk and rst.
REQ-002 clk  in  1  core clock; all state updates on the rising edge.
REQ-003 rst  in  1  synchronous reset, active-low.
REQ-004 cmd_valid  in  1  command request.
REQ-005 cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
REQ-006 cmd_op  in  2  command code: RUN=0, HALT=1, STEP=2, RUNN=3.
REQ-007 cmd_arg  in  32  instruction budget for RUNN; ignored for other commands.
REQ-008 bp_en  in  1  breakpoint enable.
REQ-009 bp_addr  in  32  breakpoint PC.
REQ-010 cur_pc  in  32  PC of the instruction the core executes at the next edge if enabled.
REQ-011 Stop_en  in  1  external stop request, level-sensitive.
REQ-012 core_en  out  1  core commits one instruction (PC and register write) at this edge.
REQ-013 halted  out  1  high iff state is HALTED.
REQ-014 halt_cause  out  3  NONE=0, CMD=1, BP=2, STOP=3, COUNT=4.
REQ-015 cmd_err  out  1  one-cycle pulse when a command is accepted and ignored.
REQ-016 cycle_cnt  out  32  count of core_en cycles.

Function
REQ-017 FSM states: HALTED, RUN, RUNN, STEP. Reset state is HALTED.
REQ-018 core_en SHALL be combinational from state, Stop_en, the breakpoint match and the accepted command. It SHALL be 0 in HALTED.
REQ-019 cmd_ready SHALL be 1 in HALTED (when Stop_en=0), RUN and RUNN. It SHALL be 0 in STEP, and 0 in HALTED while Stop_en=1.
REQ-020 Commands accepted in HALTED:
- RUN -> RUN.
- STEP -> STEP.
- RUNN with cmd_arg>0 -> RUNN, remaining<=cmd_arg.
- RUNN with cmd_arg=0 -> stay HALTED, cause COUNT.
- HALT -> stay HALTED, cause CMD.
REQ-021 In RUN/RUNN, only HALT takes effect. An accepted HALT forces core_en=0 that cycle, next state HALTED, cause CMD. Any other accepted command is ignored and pulses cmd_err next cycle.
REQ-022 Breakpoint match = bp_en && cur_pc==bp_addr, evaluated in RUN/RUNN only. A match forces core_en=0 that cycle, next state HALTED, cause BP.
REQ-023 Breakpoint suppression flag bp_skip:
- Set on every transition HALTED->RUN/RUNN.
- Masks the match on the first cycle in RUN/RUNN; cleared after that cycle.
- Allows resuming from a breakpoint PC.
REQ-024 Stop_en=1 in RUN/RUNN/STEP forces core_en=0 that cycle, next state HALTED, cause STOP.
REQ-025 Same-cycle priority: Stop_en > HALT cmd > breakpoint > budget exhaustion.
REQ-026 STEP: core_en=1 for exactly one cycle (unless REQ-024 applies), then HALTED, cause COUNT. Breakpoint is not evaluated in STEP.
REQ-027 RUNN: remaining decrements on each core_en cycle. A core_en cycle with remaining==1 leads to HALTED, cause COUNT, after exactly cmd_arg instructions.
REQ-028 cycle_cnt SHALL increment by 1 on each core_en cycle and wrap 0xFFFFFFFF->0.
REQ-029 halt_cause SHALL be written only on entry to HALTED or on a HALTED-state HALT/RUNN(0) command. It holds otherwise.

Reset
REQ-030 While rst=0 at a rising edge the block SHALL reset to: state=HALTED, halted=1, halt_cause=NONE, cycle_cnt=0, remaining=0, bp_skip=0, cmd_err=0.
REQ-031 core_en and cmd_ready SHALL be 0 while rst=0, regardless of other inputs.
REQ-032 Reset asserted mid-RUN/RUNN SHALL abandon the budget. No core_en is asserted in the reset cycle.

Structure
REQ-033 Package rv32_ctrl_pkg SHALL hold the state enum, the cmd_op enum and the halt_cause enum. It is shared with the core top and the benches.
REQ-034 No sub-module is required. The FSM, budget counter and cycle counter SHALL be implemented inline.

Verification
REQ-035 Reset, then RUN with bp_en=0, 10 cycles, then HALT -> core_en=1 for exactly 10 cycles, cycle_cnt=10, cause CMD.
REQ-036 RUNN cmd_arg=5 -> exactly 5 core_en cycles, then halted=1, cause COUNT. RUNN cmd_arg=0 -> no core_en, cause COUNT.
REQ-037 bp_addr=0x10, RUN from pc 0 (pc += 4) -> halt with cur_pc=0x10, cause BP, cycle_cnt=4. RUN again -> core_en=1 at pc 0x10, execution continues.
REQ-038 STEP three times -> exactly 3 single core_en cycles, cycle_cnt=3. cmd_ready=0 during each STEP cycle.
REQ-039 In RUN, assert Stop_en and HALT in the same cycle -> core_en=0, cause STOP. While Stop_en stays 1 in HALTED, cmd_ready=0.
REQ-040 Preload cycle_cnt to 0xFFFFFFFE (force), 3 core_en cycles -> cycle_cnt=1. Assert rst low mid-RUNN -> state HALTED, all outputs per REQ-030.
